sipo_rx: RTL and testbench

//  Receive-side deserializer paired with the 10-bit LSB-first serializer (piso).
//  - Samples one serial bit per clk while rx_en is high.
//  - Hunts for a comma word to find the word boundary.
//  - After lock, emits each aligned 10-bit word on dout with a one-cycle dout_valid strobe.
//  - Sits between the serial line and the 8b/10b decoder.

---
 rtl/sipo_rx_if.sv | 24 ++
 rtl/sipo_rx.sv | 107 ++++++++++
 tb/tb_sipo_rx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_if.sv
// rtl/sipo_rx_if.sv - serial line and aligned-word signal bundle for sipo_rx
interface sipo_rx_if #(
   parameter int W = 10
) ();
   logic         din;
   logic         rx_en;
   logic         relock;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         locked;
   logic         comma_det;

   // Line side: drives serial bits and control, observes aligned words
   modport master (
      output din, rx_en, relock,
      input  dout, dout_valid, locked, comma_det
   );

   // Deserializer side
   modport slave (
      input  din, rx_en, relock,
      output dout, dout_valid, locked, comma_det
   );
endinterface

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - comma-aligned 10-bit LSB-first deserializer; optional SIPO_REALIGN_EN enables in-lock realignment
module sipo_rx #(
   parameter int           W       = 10,
   parameter logic [W-1:0] COMMA_N = 10'b1100000101,
   parameter logic [W-1:0] COMMA_P = 10'b0011111010
) (
   input logic       i_clk,
   input logic       i_reset,   // asynchronous, active-low
   sipo_rx_if.slave  bus
);
   typedef enum logic {HUNT, LOCKED} state_t;

   state_t       r_state;
   logic [W-1:0] r_shift_reg;
   logic [W-1:0] r_bit_cnt;
   logic [W-1:0] r_dout;
   logic         r_dout_valid;
   logic         r_comma_det;

   state_t       w_state_nxt;
   logic [W-1:0] w_shift_nxt;
   logic [W-1:0] w_bit_cnt_nxt;
   logic [W-1:0] w_dout_nxt;
   logic         w_dout_valid_nxt;
   logic         w_comma_det_nxt;

   logic [W-1:0] w_win;
   logic         w_is_comma;
   logic         w_last_bit;

   // Newest bit enters at the top so the first-received bit ends in bit 0
   assign w_win      = {bus.din, r_shift_reg[W-1:1]};
   assign w_is_comma = (w_win == COMMA_N) || (w_win == COMMA_P);
   assign w_last_bit = (r_bit_cnt == W'(W - 1));

   // Next-state and next-output decode; relock outranks every other event
   always_comb begin
      w_state_nxt      = r_state;
      w_shift_nxt      = r_shift_reg;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_dout_nxt       = r_dout;
      w_dout_valid_nxt = 1'b0;
      w_comma_det_nxt  = 1'b0;

      if (bus.relock) begin
         w_state_nxt   = HUNT;
         w_shift_nxt   = '0;
         w_bit_cnt_nxt = '0;
      end else if (bus.rx_en) begin
         w_shift_nxt = w_win;
         case (r_state)
            HUNT: begin
               if (w_is_comma) begin
                  w_dout_nxt       = w_win;
                  w_dout_valid_nxt = 1'b1;
                  w_comma_det_nxt  = 1'b1;
                  w_bit_cnt_nxt    = '0;
                  w_state_nxt      = LOCKED;
               end
            end
            LOCKED: begin
               if (w_last_bit) begin
                  w_dout_nxt       = w_win;
                  w_dout_valid_nxt = 1'b1;
                  w_comma_det_nxt  = w_is_comma;
                  w_bit_cnt_nxt    = '0;
`ifdef SIPO_REALIGN_EN
               end else if (w_is_comma) begin
                  // Misaligned comma: drop the partial word and restart the boundary here
                  w_dout_nxt       = w_win;
                  w_dout_valid_nxt = 1'b1;
                  w_comma_det_nxt  = 1'b1;
                  w_bit_cnt_nxt    = '0;
`endif
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + W'(1);
               end
            end
            default: w_state_nxt = HUNT;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= HUNT;
         r_shift_reg  <= '0;
         r_bit_cnt    <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_comma_det  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift_reg  <= w_shift_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_dout       <= w_dout_nxt;
         r_dout_valid <= w_dout_valid_nxt;
         r_comma_det  <= w_comma_det_nxt;
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_dout_valid;
   assign bus.comma_det  = r_comma_det;
   assign bus.locked     = (r_state == LOCKED);
endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - scoreboard bench for sipo_rx
module tb_sipo_rx;
   localparam logic [9:0] C_N = 10'b1100000101;
   localparam logic [9:0] C_P = 10'b0011111010;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_tests;
   int   n_fail;

   typedef struct {
      logic [9:0] d;
      logic       c;
      int         at;
   } exp_t;

   exp_t exp_q[$];

   sipo_rx_if #(.W(10)) bus ();

   sipo_rx dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (bus.comma_det && !bus.dout_valid)
         chk("comma_det_without_valid", 32'(bus.comma_det), 32'd0);
      if (bus.dout_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 32'(bus.dout_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_dout", 32'(bus.dout), 32'(e.d));
            chk("strobe_comma_det", 32'(bus.comma_det), 32'(e.c));
            chk("strobe_cycle", 32'(cyc), 32'(e.at));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.din    = b;
      bus.rx_en  = 1'b1;
      bus.relock = 1'b0;
      tick();
   endtask

   task automatic idle(input int n);
      bus.din   = 1'b0;
      bus.rx_en = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   // Expect a strobe on the dly-th upcoming clock edge
   task automatic expect_at(input logic [9:0] d, input logic c, input int dly);
      exp_t e;
      e.d  = d;
      e.c  = c;
      e.at = cyc + dly;
      exp_q.push_back(e);
   endtask

   task automatic relock_pulse();
      bus.relock = 1'b1;
      bus.rx_en  = 1'b0;
      tick();
      bus.relock = 1'b0;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      bus.din    = 1'b0;
      bus.rx_en  = 1'b0;
      bus.relock = 1'b0;
      #1;
      repeat (2) tick();
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_locked", 32'(bus.locked), 32'd0);
      chk("rst_comma_det", 32'(bus.comma_det), 32'd0);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] w;
      cyc     = 0;
      n_tests = 0;
      n_fail  = 0;
      do_reset();

      // T2: alternating pattern never looks like a comma
      for (int i = 0; i < 200; i++) send_bit(i[0] == 1'b0);
      chk("t2_locked", 32'(bus.locked), 32'd0);
      chk("t2_dout", 32'(bus.dout), 32'd0);

      // T1: lock on COMMA_N after three idle bits, then one data word
      do_reset();
      repeat (3) send_bit(1'b0);
      expect_at(C_N, 1'b1, 10);
      send_word(C_N);
      chk("t1_locked", 32'(bus.locked), 32'd1);
      expect_at(10'h2AA, 1'b0, 10);
      send_word(10'h2AA);

      // T3: four disabled cycles inside a word stretch it to 14 cycles
      w = 10'h3C1;
      expect_at(w, 1'b0, 14);
      for (int i = 0; i < 5; i++) send_bit(w[i]);
      idle(4);
      for (int i = 5; i < 10; i++) send_bit(w[i]);

      // T4: relock on the last bit of a word suppresses the strobe
      w = 10'h0F0;
      for (int i = 0; i < 9; i++) send_bit(w[i]);
      bus.din    = w[9];
      bus.rx_en  = 1'b1;
      bus.relock = 1'b1;
      tick();
      bus.relock = 1'b0;
      chk("t4_locked_dropped", 32'(bus.locked), 32'd0);
      chk("t4_dout_kept", 32'(bus.dout), 32'h3C1);
      expect_at(C_P, 1'b1, 10);
      send_word(C_P);
      chk("t4_relocked", 32'(bus.locked), 32'd1);

      // T5: COMMA_P shifted by three bits
      expect_at(10'h3D0, 1'b0, 10);
`ifdef SIPO_REALIGN_EN
      expect_at(C_P, 1'b1, 13);
      expect_at(10'h2AA, 1'b0, 23);
`else
      expect_at(10'h151, 1'b0, 20);
`endif
      repeat (3) send_bit(1'b0);
      send_word(C_P);
      send_word(10'h2AA);
      chk("t5_locked", 32'(bus.locked), 32'd1);
      relock_pulse();
      expect_at(C_N, 1'b1, 10);
      send_word(C_N);

      // T6: asynchronous reset in the middle of a word
      w = 10'h155;
      for (int i = 0; i < 6; i++) send_bit(w[i]);
      bus.rx_en = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("t6_dout", 32'(bus.dout), 32'd0);
      chk("t6_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("t6_locked", 32'(bus.locked), 32'd0);
      chk("t6_comma_det", 32'(bus.comma_det), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (4) send_bit(1'b0);
      chk("t6_still_hunting", 32'(bus.locked), 32'd0);
      expect_at(C_N, 1'b1, 10);
      send_word(C_N);
      chk("t6_relocked", 32'(bus.locked), 32'd1);

      idle(3);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
